mosfet_sort_seq: RTL

MOSFET_SORT_SEQ -- requirements
Module: mosfet_sort_seq

---
 rtl/mosfet_sort_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/mosfet_sort_seq.sv
// Frame-based MOSFET metric sorter: computes ID or gm per device beat, keeps a
// descending insertion-sorted array, and emits a weighted top/bottom-three sum.
module mosfet_sort_seq #(
  parameter int N_DEV = 6,
  parameter int VW    = 3,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [VW-1:0]    W,
  input  logic [VW-1:0]    V_GS,
  input  logic [VW-1:0]    V_DS,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n
);

  localparam int MW = 3*VW + 1;
  localparam int SW = MW + 4;
  localparam int CW = $clog2(N_DEV + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       frame_mode;
  logic [MW-1:0]    sorted [N_DEV];
  logic [MW-1:0]    base   [N_DEV];
  logic [MW-1:0]    ins    [N_DEV];
  logic [N_DEV-1:0] ge;
  logic             accept, first, last, sel_id;
  logic [VW-1:0]    vov;
  logic [VW:0]      trio_term;
  logic [MW-1:0]    id_val, gm_val, metric;
  logic [MW-1:0]    a, b, c;
  logic [SW-1:0]    sum_full;

  assign accept = in_valid && (state != CALC);
  assign first  = (cnt == '0);
  assign last   = (cnt == CW'(N_DEV - 1));
  assign sel_id = first ? mode[0] : frame_mode[0];

  // Full-precision products, single truncating divide by 3 at the end.
  always_comb begin
    vov       = V_GS - VW'(1);
    trio_term = {vov, 1'b0} - {1'b0, V_DS};
    id_val    = '0;
    gm_val    = '0;
    if (V_GS != '0) begin
      if (vov > V_DS) begin
        id_val = (MW'(W) * MW'(V_DS) * MW'(trio_term)) / MW'(3);
        gm_val = (MW'(W) * MW'(V_DS) * MW'(2)) / MW'(3);
      end else begin
        id_val = (MW'(W) * MW'(vov) * MW'(vov)) / MW'(3);
        gm_val = (MW'(W) * MW'(vov) * MW'(2)) / MW'(3);
      end
    end
    metric = sel_id ? id_val : gm_val;
  end

  // The first beat of a frame inserts into an all-zero array, discarding the old frame.
  always_comb begin
    ge = '0;
    for (int i = 0; i < N_DEV; i++) begin
      base[i] = first ? '0 : sorted[i];
      ge[i]   = (base[i] >= metric);
    end
    ins[0] = ge[0] ? base[0] : metric;
    for (int i = 1; i < N_DEV; i++)
      ins[i] = ge[i] ? base[i] : (ge[i-1] ? metric : base[i-1]);
  end

  always_comb begin
    if (frame_mode[1]) begin
      a = sorted[0];
      b = sorted[1];
      c = sorted[2];
    end else begin
      a = sorted[N_DEV-3];
      b = sorted[N_DEV-2];
      c = sorted[N_DEV-1];
    end
    if (frame_mode[0])
      sum_full = SW'(a) * SW'(3) + SW'(b) * SW'(4) + SW'(c) * SW'(5);
    else
      sum_full = SW'(a) + SW'(b) + SW'(c);
  end

  // Result registers in OUT, so a new frame's first beat can overwrite the array at that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_mode <= '0;
      out_valid  <= 1'b0;
      out_n      <= '0;
      for (int i = 0; i < N_DEV; i++) sorted[i] <= '0;
    end else begin
      out_valid <= (state == OUT);
      out_n     <= (state == OUT) ? OUT_W'(sum_full) : '0;
      if (accept) begin
        for (int i = 0; i < N_DEV; i++) sorted[i] <= ins[i];
        if (first) frame_mode <= mode;
        cnt <= last ? '0 : cnt + CW'(1);
      end
      case (state)
        CALC:    state <= OUT;
        OUT:     state <= accept ? (last ? CALC : LOAD) : IDLE;
        default: if (accept) state <= last ? CALC : LOAD;
      endcase
    end
  end

endmodule
